// File: rtl/y_alu_pkg.sv
// Shared opcode encodings and operation type for the y_alu execute-stage ALU.
package y_alu_pkg;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t OP_AND = 3'b000;
    localparam alu_op_t OP_OR  = 3'b001;
    localparam alu_op_t OP_ADD = 3'b010;
    localparam alu_op_t OP_SUB = 3'b110;
    localparam alu_op_t OP_SLT = 3'b111;

endpackage

// File: rtl/y_alu_adder.sv
// y_adder: WIDTH-bit adder with carry-in, reporting carry-out and signed overflow.
module y_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign sum  = full[WIDTH-1:0];
    assign cout = full[WIDTH];
    // Signed overflow: operands agree in sign but the sum does not.
    assign ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/y_alu.sv
// y_alu: registered AND/OR/ADD/SUB ALU with zero flag and one-cycle valid.
// Set-less-than on op 111 is built only when YALU_SLT_EN is defined.
module y_alu
    import y_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_t          op,
    output logic [WIDTH-1:0] z,
    output logic             ex,
    output logic             out_valid
);

    logic             is_sub;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout_unused;
    logic             add_ovf;
    logic [WIDTH-1:0] result;

    logic [WIDTH-1:0] z_d, z_q;
    logic             ex_d, ex_q;
    logic             out_valid_d, out_valid_q;

    // SUB and SLT share the adder as a + ~b + 1.
    assign is_sub = (op == OP_SUB) || (op == OP_SLT);
    assign add_b  = is_sub ? ~b : b;

    y_adder #(.WIDTH(WIDTH)) u_adder (
        .a    (a),
        .b    (add_b),
        .cin  (is_sub),
        .sum  (add_sum),
        .cout (add_cout_unused),
        .ovf  (add_ovf)
    );

`ifdef YALU_SLT_EN
    logic slt;
    assign slt = add_sum[WIDTH-1] ^ add_ovf;
`else
    logic ovf_unused;
    assign ovf_unused = add_ovf;
`endif

    always_comb begin
        result = '0;
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_ADD:  result = add_sum;
            OP_SUB:  result = add_sum;
`ifdef YALU_SLT_EN
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, slt};
`endif
            default: result = '0;
        endcase
    end

    always_comb begin
        z_d         = z_q;
        ex_d        = ex_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            z_d  = result;
            ex_d = (result == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q         <= '0;
            ex_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            z_q         <= z_d;
            ex_q        <= ex_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign z         = z_q;
    assign ex        = ex_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_y_alu.sv
// Scoreboard bench for y_alu: stimulus pushes expected results, a monitor pops on out_valid.
module tb_y_alu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] z;
    logic        ex;
    logic        out_valid;

    typedef struct {
        logic [31:0] z;
        logic        ex;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   done     = 0;

    y_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .op        (op),
        .z         (z),
        .ex        (ex),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, req);
    endtask

    task automatic issue(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] top,
                         input logic [31:0] exp_z);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        a        = ta;
        b        = tb;
        op       = top;
        e.z      = exp_z;
        e.ex     = (exp_z == 32'h0);
        exp_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        a        = 32'hDEAD_BEEF;
        b        = 32'h0BAD_F00D;
        op       = 3'b010;
    endtask

    // Monitor: every edge with a pending expectation must present a matching result.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done) break;
            if (rst_n !== 1'b1) continue;
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 32'(out_valid), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("result_z", z, e.z);
                    check("result_ex", 32'(ex), 32'(e.ex));
                end
            end else if (exp_q.size() != 0) begin
                check("late_out_valid", 32'(out_valid), 32'h1);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] slt_neg_pos;
        logic [31:0] slt_pos_neg;
        logic [31:0] slt_ovf;
`ifdef YALU_SLT_EN
        slt_neg_pos = 32'h1;
        slt_pos_neg = 32'h0;
        slt_ovf     = 32'h1;
`else
        slt_neg_pos = 32'h0;
        slt_pos_neg = 32'h0;
        slt_ovf     = 32'h0;
`endif
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        op       = '0;
        rst_n    = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("reset_z", z, 32'h0);
        check("reset_ex", 32'(ex), 32'h0);
        check("reset_out_valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed operations from the test plan.
        issue(32'hF0F0_1234, 32'h0FF0_FFFF, 3'b000, 32'h00F0_1234);
        issue(32'hF0F0_1234, 32'h0FF0_FFFF, 3'b001, 32'hFFF0_FFFF);
        issue(32'hFFFF_FFFF, 32'h0000_0001, 3'b010, 32'h0000_0000);
        issue(32'h0000_0005, 32'h0000_0007, 3'b110, 32'hFFFF_FFFE);
        issue(32'h1234_5678, 32'h1234_5678, 3'b110, 32'h0000_0000);
        issue(32'h0000_0003, 32'h0000_0009, 3'b011, 32'h0000_0000);
        issue(32'hFFFF_FFFF, 32'h0000_0001, 3'b111, slt_neg_pos);
        issue(32'h0000_0001, 32'hFFFF_FFFF, 3'b111, slt_pos_neg);
        issue(32'h8000_0000, 32'h0000_0001, 3'b111, slt_ovf);
        idle();

        // Ten back-to-back operations, then one idle edge.
        issue(32'hFFFF_0000, 32'h1234_5678, 3'b000, 32'h1234_0000);
        issue(32'h0000_0001, 32'h8000_0000, 3'b001, 32'h8000_0001);
        issue(32'h7FFF_FFFF, 32'h0000_0001, 3'b010, 32'h8000_0000);
        issue(32'h0000_0000, 32'h0000_0001, 3'b110, 32'hFFFF_FFFF);
        issue(32'h0000_0064, 32'h0000_00C8, 3'b010, 32'h0000_012C);
        issue(32'h8000_0000, 32'h0000_0001, 3'b110, 32'h7FFF_FFFF);
        issue(32'h0000_0005, 32'h0000_0005, 3'b100, 32'h0000_0000);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b101, 32'h0000_0000);
        issue(32'hAAAA_AAAA, 32'h5555_5555, 3'b000, 32'h0000_0000);
        issue(32'h0001_0000, 32'h0000_FFFF, 3'b010, 32'h0001_FFFF);
        idle();
        @(posedge clk);
        #1;
        check("idle_out_valid", 32'(out_valid), 32'h0);
        check("idle_hold_z", z, 32'h0001_FFFF);
        check("idle_hold_ex", 32'(ex), 32'h0);

        // Asynchronous reset while a result is being presented.
        issue(32'h1234_0000, 32'h0000_5678, 3'b001, 32'h1234_5678);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        check("pre_reset_out_valid", 32'(out_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_z", z, 32'h0);
        check("mid_reset_ex", 32'(ex), 32'h0);
        check("mid_reset_out_valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // First operation after reset release.
        issue(32'h0000_0010, 32'h0000_0020, 3'b010, 32'h0000_0030);
        idle();
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        done = 1;
        @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
